// File: rtl/gpr_dbg_pkg.sv
// Shared types and constants for the debug-side GPR access block.
// Holds the FSM state encoding, register index width and the x0 index.
// The READBACK state only exists when GPR_DBG_READBACK_EN is defined.
package gpr_dbg_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

  // Explicit encodings keep RESP at the same value in both builds.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HALT     = 3'd1,
    ST_ACCESS   = 3'd2,
`ifdef GPR_DBG_READBACK_EN
    ST_READBACK = 3'd3,
`endif
    ST_RESP     = 3'd4
  } gpr_dbg_state_e;

  // x0 is hardwired to zero in the register file.
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
    return addr == X0_ADDR;
  endfunction

endpackage

// File: rtl/gpr_debug_access.sv
// Debug initiator: halts the core and performs one GPR read or write per request.
// Latency: response 3 cycles after the request handshake (4 with GPR_DBG_READBACK_EN), plus halt wait.
// Backpressure: one request in flight; the response holds until dbg_rsp_ready_i, no new request before then.
module gpr_debug_access
  import gpr_dbg_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  // debug request channel
  input  logic                  dbg_req_valid_i,
  output logic                  dbg_req_ready_o,
  input  logic                  dbg_req_write_i,
  input  logic [REG_ADDR_W-1:0] dbg_req_addr_i,
  input  logic [XLEN-1:0]       dbg_req_wdata_i,
  // debug response channel
  output logic                  dbg_rsp_valid_o,
  input  logic                  dbg_rsp_ready_i,
  output logic [XLEN-1:0]       dbg_rsp_rdata_o,
  output logic                  dbg_rsp_err_o,
  // core halt handshake
  output logic                  core_halt_req_o,
  input  logic                  core_halted_i,
  // register-file ports
  output logic [REG_ADDR_W-1:0] rf_rs1_addr_o,
  input  logic [XLEN-1:0]       rf_rs1_data_i,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_o,
  output logic                  rf_wr_en_o,
  output logic [XLEN-1:0]       rf_wr_data_o
);

  // Counter only needs to reach HALT_TIMEOUT; it never counts past it.
  localparam int CNT_W = (HALT_TIMEOUT > 0) ? $clog2(HALT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALT_TIMEOUT);

  gpr_dbg_state_e        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic req_fire;
  logic in_access;
  logic acc_err;

  assign dbg_req_ready_o = (state_q == ST_IDLE) && !reset;
  assign req_fire        = dbg_req_valid_i && dbg_req_ready_o;
  assign in_access       = (state_q == ST_ACCESS);

  // Losing the halt mid-access or targeting x0 with a write aborts the access.
  assign acc_err = !core_halted_i || (write_q && is_x0(addr_q));

  // Next-state logic for the request FSM, halt timeout and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          write_d = dbg_req_write_i;
          addr_d  = dbg_req_addr_i;
          wdata_d = dbg_req_wdata_i;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        if (core_halted_i) begin
          state_d = ST_ACCESS;
        end else if (cnt_q == CNT_MAX) begin
          // Core never halted: fail without touching the register file.
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_ACCESS: begin
        err_d = acc_err;
        // Reads of x0 return zero regardless of what the port returns.
        if (acc_err || write_q || is_x0(addr_q)) begin
          rdata_d = '0;
        end else begin
          rdata_d = rf_rs1_data_i;
        end
`ifdef GPR_DBG_READBACK_EN
        if (write_q && !acc_err) begin
          state_d = ST_READBACK;
        end else begin
          state_d = ST_RESP;
        end
`else
        state_d = ST_RESP;
`endif
      end

`ifdef GPR_DBG_READBACK_EN
      ST_READBACK: begin
        // The write committed at the end of ACCESS, so the port now shows the new value.
        rdata_d = rf_rs1_data_i;
        err_d   = (rf_rs1_data_i != wdata_q) || !core_halted_i;
        state_d = ST_RESP;
      end
`endif

      ST_RESP: begin
        if (dbg_rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Register-file port drive: quiet (all zero) outside the access cycles.
  always_comb begin
    rf_wr_en_o    = 1'b0;
    rf_rd_addr_o  = '0;
    rf_wr_data_o  = '0;
    rf_rs1_addr_o = '0;
    if (in_access && write_q) begin
      rf_wr_en_o   = core_halted_i && !is_x0(addr_q);
      rf_rd_addr_o = addr_q;
      rf_wr_data_o = wdata_q;
    end
    if (in_access && !write_q) begin
      rf_rs1_addr_o = addr_q;
    end
`ifdef GPR_DBG_READBACK_EN
    if (state_q == ST_READBACK) begin
      rf_rs1_addr_o = addr_q;
    end
`endif
  end

  assign core_halt_req_o = (state_q != ST_IDLE);
  assign dbg_rsp_valid_o = (state_q == ST_RESP);
  assign dbg_rsp_rdata_o = rdata_q;
  assign dbg_rsp_err_o   = err_q;

`ifndef SYNTHESIS
  // A write strobe outside ACCESS would corrupt the core's registers.
  a_wr_only_in_access: assert property (@(posedge clk) disable iff (reset)
    rf_wr_en_o |-> (state_q == ST_ACCESS));

  // Requests and responses never overlap.
  a_one_outstanding: assert property (@(posedge clk) disable iff (reset)
    dbg_rsp_valid_o |-> !dbg_req_ready_o);
`endif

endmodule

// File: tb/tb_gpr_debug_access.sv
// Self-checking bench for gpr_debug_access with a behavioural register file.
// Responses are checked against a scoreboard queue filled when requests are accepted.
// Also exercises halt timeout, halt loss, response backpressure and reset mid-write.
module tb_gpr_debug_access;

  localparam int XLEN = 32;
  localparam int HT   = 4;
`ifdef GPR_DBG_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            dbg_req_valid_i, dbg_req_ready_o, dbg_req_write_i;
  logic [4:0]      dbg_req_addr_i;
  logic [XLEN-1:0] dbg_req_wdata_i;
  logic            dbg_rsp_valid_o, dbg_rsp_ready_i, dbg_rsp_err_o;
  logic [XLEN-1:0] dbg_rsp_rdata_o;
  logic            core_halt_req_o, core_halted_i;
  logic [4:0]      rf_rs1_addr_o, rf_rd_addr_o;
  logic [XLEN-1:0] rf_rs1_data_i, rf_wr_data_o;
  logic            rf_wr_en_o;

  gpr_debug_access #(.XLEN(XLEN), .HALT_TIMEOUT(HT)) dut (
    .clk(clk), .reset(reset),
    .dbg_req_valid_i(dbg_req_valid_i), .dbg_req_ready_o(dbg_req_ready_o),
    .dbg_req_write_i(dbg_req_write_i), .dbg_req_addr_i(dbg_req_addr_i),
    .dbg_req_wdata_i(dbg_req_wdata_i),
    .dbg_rsp_valid_o(dbg_rsp_valid_o), .dbg_rsp_ready_i(dbg_rsp_ready_i),
    .dbg_rsp_rdata_o(dbg_rsp_rdata_o), .dbg_rsp_err_o(dbg_rsp_err_o),
    .core_halt_req_o(core_halt_req_o), .core_halted_i(core_halted_i),
    .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs1_data_i(rf_rs1_data_i),
    .rf_rd_addr_o(rf_rd_addr_o), .rf_wr_en_o(rf_wr_en_o),
    .rf_wr_data_o(rf_wr_data_o)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural register file with a backdoor for presetting contents.
  logic [31:0] rf_mem [32];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  int          wr_count = 0;
  logic [4:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  assign rf_rs1_data_i = rf_mem[rf_rs1_addr_o];

  always @(posedge clk) begin
    if (bd_we) rf_mem[bd_addr] <= bd_data;
    if (rf_wr_en_o) begin
      rf_mem[rf_rd_addr_o] <= rf_wr_data_o;
      wr_count     <= wr_count + 1;
      last_wr_addr <= rf_rd_addr_o;
      last_wr_data <= rf_wr_data_o;
    end
  end

  task automatic bd_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Scoreboard of expected responses.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          hs;
  } exp_t;
  exp_t sbq[$];

  int first_cyc = 0;
  int last_rsp_cyc = 0;
  int last_hs = 0;
  int port_act = 0;

  // Response monitor, sampling on the falling edge.
  initial begin
    logic        prev_valid;
    logic [31:0] prev_rdata;
    logic        prev_err;
    exp_t        e;
    prev_valid = 1'b0;
    prev_rdata = '0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rf_wr_en_o || rf_rs1_addr_o != 0 || rf_rd_addr_o != 0 || rf_wr_data_o != 0)
        port_act++;
      if (dbg_rsp_valid_o && !prev_valid) first_cyc = cyc;
      if (dbg_rsp_valid_o && prev_valid) begin
        chk("rsp_rdata_stable", dbg_rsp_rdata_o, prev_rdata);
        chk("rsp_err_stable", 32'(dbg_rsp_err_o), 32'(prev_err));
      end
      if (dbg_rsp_valid_o) chk("req_ready_during_rsp", 32'(dbg_req_ready_o), 32'd0);
      if (dbg_rsp_valid_o && dbg_rsp_ready_i) begin
        last_rsp_cyc = cyc;
        if (sbq.size() == 0) begin
          nchecks++; nerrors++;
          $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response",
                   dbg_rsp_rdata_o, dbg_rsp_err_o);
        end else begin
          e = sbq.pop_front();
          chk("rsp_rdata", dbg_rsp_rdata_o, e.rdata);
          chk("rsp_err", 32'(dbg_rsp_err_o), 32'(e.err));
          chk("rsp_latency", 32'(first_cyc - e.hs), 32'(e.lat));
        end
      end
      prev_valid = dbg_rsp_valid_o && !dbg_rsp_ready_i;
      prev_rdata = dbg_rsp_rdata_o;
      prev_err   = dbg_rsp_err_o;
    end
  end

  // Issue one request; d = halt delay in cycles, negative = core never halts.
  task automatic send(input logic wr, input logic [4:0] a, input logic [31:0] wd, input int d,
                      input logic [31:0] er, input logic ee, input int el);
    int n;
    exp_t e;
    @(negedge clk);
    core_halted_i   = (d == 0);
    dbg_req_valid_i = 1'b1;
    dbg_req_write_i = wr;
    dbg_req_addr_i  = a;
    dbg_req_wdata_i = wd;
    n = 0;
    while (!dbg_req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!dbg_req_ready_o) begin
      nchecks++; nerrors++;
      $display("FAIL req_accept_timeout: got ready 0 after %0d cycles, expected 1", n);
      dbg_req_valid_i = 1'b0;
      return;
    end
    last_hs = cyc;
    e.rdata = er; e.err = ee; e.lat = el; e.hs = cyc;
    sbq.push_back(e);
    @(negedge clk);
    dbg_req_valid_i = 1'b0;
    chk("halt_req_busy", 32'(core_halt_req_o), 32'd1);
    if (d > 0) begin
      repeat (d) @(negedge clk);
      core_halted_i = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      nchecks++; nerrors++;
      $display("FAIL rsp_timeout: got %0d pending responses, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          d;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int w0;
    int p0;
    int n;

    vecs[0] = '{1'b0, 5'd5,  32'h0,        0, 32'hDEADBEEF, 1'b0, 3, 0};
    vecs[1] = '{1'b1, 5'd10, 32'h12345678, 0, (RB != 0) ? 32'h12345678 : 32'h0, 1'b0, 3 + RB, 1};
    vecs[2] = '{1'b0, 5'd10, 32'h0,        0, 32'h12345678, 1'b0, 3, 0};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 0, 32'h0,        1'b1, 3, 0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        0, 32'h0,        1'b0, 3, 0};
    vecs[5] = '{1'b0, 5'd5,  32'h0,        2, 32'hDEADBEEF, 1'b0, 5, 0};
    vecs[6] = '{1'b1, 5'd31, 32'hCAFEF00D, 1, (RB != 0) ? 32'hCAFEF00D : 32'h0, 1'b0, 4 + RB, 1};
    vecs[7] = '{1'b0, 5'd31, 32'h0,        3, 32'hCAFEF00D, 1'b0, 6, 0};

    reset = 1'b1;
    dbg_req_valid_i = 1'b0; dbg_req_write_i = 1'b0;
    dbg_req_addr_i = '0; dbg_req_wdata_i = '0;
    dbg_rsp_ready_i = 1'b1; core_halted_i = 1'b0;

    // x0 holds garbage in the model so a missing zero-force shows up.
    bd_write(5'd0,  32'hA5A5A5A5);
    bd_write(5'd5,  32'hDEADBEEF);
    bd_write(5'd12, 32'h0BADF00D);

    @(negedge clk);
    chk("rst_req_ready", 32'(dbg_req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(dbg_rsp_valid_o), 32'd0);
    chk("rst_rsp_err",   32'(dbg_rsp_err_o),   32'd0);
    chk("rst_rsp_rdata", dbg_rsp_rdata_o,      32'd0);
    chk("rst_halt_req",  32'(core_halt_req_o), 32'd0);
    chk("rst_wr_en",     32'(rf_wr_en_o),      32'd0);
    chk("rst_ports",     {rf_rs1_addr_o, rf_rd_addr_o} | rf_wr_data_o, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(dbg_req_ready_o), 32'd1);
    chk("post_rst_halt_req",  32'(core_halt_req_o), 32'd0);

    // Table-driven reads and writes.
    for (int i = 0; i < 8; i++) begin
      w0 = wr_count;
      send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].d,
           vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
      drain();
      chk($sformatf("vec%0d_write_count", i), 32'(wr_count - w0), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr != 0) begin
        chk($sformatf("vec%0d_wr_addr", i), 32'(last_wr_addr), 32'(vecs[i].addr));
        chk($sformatf("vec%0d_wr_data", i), last_wr_data, vecs[i].wdata);
      end
    end

    // Core unhalts during the access cycle of a write.
    w0 = wr_count;
    send(1'b1, 5'd7, 32'h77777777, 0, 32'h0, 1'b1, 3);
    @(negedge clk);
    core_halted_i = 1'b0;
    drain();
    chk("halt_drop_no_write", 32'(wr_count - w0), 32'd0);

    // Halt timeout: core never halts.
    p0 = port_act;
    w0 = wr_count;
    send(1'b0, 5'd5, 32'h0, -1, 32'h0, 1'b1, HT + 2);
    drain();
    chk("timeout_port_activity", 32'(port_act - p0), 32'd0);
    chk("timeout_no_write", 32'(wr_count - w0), 32'd0);
    @(negedge clk);
    chk("timeout_halt_released", 32'(core_halt_req_o), 32'd0);

    // Response backpressure with a second request waiting.
    dbg_rsp_ready_i = 1'b0;
    send(1'b0, 5'd10, 32'h0, 0, 32'h12345678, 1'b0, 3);
    fork
      send(1'b0, 5'd5, 32'h0, 0, 32'hDEADBEEF, 1'b0, 3);
      begin
        n = 0;
        while (!dbg_rsp_valid_o && n < 20) begin
          @(negedge clk);
          n++;
        end
        repeat (10) begin
          @(negedge clk);
          chk("bp_req_ready", 32'(dbg_req_ready_o), 32'd0);
          chk("bp_rsp_valid", 32'(dbg_rsp_valid_o), 32'd1);
        end
        @(posedge clk);
        #1;
        dbg_rsp_ready_i = 1'b1;
      end
    join
    chk("bp_second_accept_cycle", 32'(last_hs), 32'(last_rsp_cyc + 1));
    drain();

    // Reset asserted during the access cycle of a write.
    w0 = wr_count;
    @(negedge clk);
    core_halted_i   = 1'b1;
    dbg_req_valid_i = 1'b1;
    dbg_req_write_i = 1'b1;
    dbg_req_addr_i  = 5'd12;
    dbg_req_wdata_i = 32'h55AA55AA;
    chk("rst_seq_ready", 32'(dbg_req_ready_o), 32'd1);
    @(negedge clk);
    dbg_req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_seq_in_access", 32'(rf_wr_en_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_seq_wr_en", 32'(rf_wr_en_o), 32'd0);
    chk("rst_seq_halt_req", 32'(core_halt_req_o), 32'd0);
    chk("rst_seq_rsp_valid", 32'(dbg_rsp_valid_o), 32'd0);
    chk("rst_seq_req_ready", 32'(dbg_req_ready_o), 32'd0);
    chk("rst_seq_ports", {rf_rs1_addr_o, rf_rd_addr_o} | rf_wr_data_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_seq_ready_after", 32'(dbg_req_ready_o), 32'd1);
    chk("rst_seq_no_write", 32'(wr_count - w0), 32'd0);
    chk("rst_seq_mem_intact", rf_mem[12], 32'h0BADF00D);
    send(1'b0, 5'd12, 32'h0, 0, 32'h0BADF00D, 1'b0, 3);
    drain();
    send(1'b1, 5'd12, 32'h55AA55AA, 0, (RB != 0) ? 32'h55AA55AA : 32'h0, 1'b0, 3 + RB);
    drain();
    send(1'b0, 5'd12, 32'h0, 0, 32'h55AA55AA, 1'b0, 3);
    drain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    nerrors++;
    $display("FAIL watchdog: got no completion by %0t, expected finish earlier", $time);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $fatal(1, "watchdog expired");
  end

endmodule
